// File: rtl/marie_pkg.sv
// Shared MARIE definitions used by the control unit and the memory operations.
package marie_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int OPND_W = 16;

    // Opcodes, kept here so the control unit, Load and Store decode the same values.
    localparam logic [3:0] OPC_LOAD  = 4'b0001;
    localparam logic [3:0] OPC_STORE = 4'b0010;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAR,
        LOAD_MBR,
        WRITE,
        FINISH
    } store_state_t;

endpackage

// File: rtl/mem_write_port.sv
// Single-word memory write handshake with a wait-state timeout.
// The write is held for as long as req is high. ack fires on the cycle the
// memory accepts the write. timeout fires on the last permitted wait cycle.
module mem_write_port
    import marie_pkg::*;
#(
    parameter int AW       = ADDR_W,
    parameter int DW       = DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_ack,
    output logic          o_timeout
);

    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] LP_SAT  = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_cnt;

    // Count unanswered write cycles, saturating so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_req && !i_ready && (r_cnt != LP_SAT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_we      = i_req;
    assign o_addr    = i_addr;
    assign o_data    = i_data;
    assign o_ack     = i_req & i_ready;
    assign o_timeout = i_req & ~i_ready & (r_cnt == LP_LAST);

endmodule

// File: rtl/store_unit.sv
// Store X: MAR <- X, MBR <- AC, M[MAR] <- MBR.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for start; out-of-range X goes straight to FINISH
//   LOAD_MAR | MAR <= captured X
//   LOAD_MBR | MBR <= AC, wait counter cleared
//   WRITE    | mem_we held until mem_ready or timeout
//   FINISH   | one-cycle done, err valid
//
// mem_we, busy and done are decoded from the state register only, so an
// asynchronous reset removes a pending write immediately.
module store_unit
    import marie_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OPND_W-1:0] X,
    input  logic [DATA_W-1:0] AC,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] MAR,
    output logic [DATA_W-1:0] MBR
);

    store_state_t      r_state;
    store_state_t      w_state_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [ADDR_W-1:0] r_x;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mbr;
    logic              w_x_oor;
    logic              w_clr;
    logic              w_req;
    logic              w_ack;
    logic              w_timeout;

    assign w_x_oor = (X[OPND_W-1:ADDR_W] != '0);
    assign w_clr   = (r_state == LOAD_MBR);
    assign w_req   = (r_state == WRITE);

    // State register; err is latched on the transition into FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_x_oor) begin
                        w_state_nxt = FINISH;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = LOAD_MAR;
                    end
                end
            end
            LOAD_MAR: w_state_nxt = LOAD_MBR;
            LOAD_MBR: w_state_nxt = WRITE;
            WRITE: begin
                if (w_ack) begin
                    w_state_nxt = FINISH;
                end else if (w_timeout) begin
                    w_state_nxt = FINISH;
                    w_err_nxt   = 1'b1;
                end
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture and the MAR/MBR register transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_mar <= '0;
            r_mbr <= '0;
        end else begin
            if ((r_state == IDLE) && start && !w_x_oor) begin
                r_x <= X[ADDR_W-1:0];
            end
            if (r_state == LOAD_MAR) begin
                r_mar <= r_x;
            end
            if (r_state == LOAD_MBR) begin
                r_mbr <= AC;
            end
        end
    end

    mem_write_port #(
        .AW       (ADDR_W),
        .DW       (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wport (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_req     (w_req),
        .i_addr    (r_mar),
        .i_data    (r_mbr),
        .i_ready   (mem_ready),
        .o_we      (mem_we),
        .o_addr    (mem_addr),
        .o_data    (mem_wdata),
        .o_ack     (w_ack),
        .o_timeout (w_timeout)
    );

    assign busy = (r_state != IDLE);
    assign done = (r_state == FINISH);
    assign err  = (r_state == FINISH) & r_err;
    assign MAR  = r_mar;
    assign MBR  = r_mbr;

endmodule
